stim_pattern_gen: RTL and testbench

Synthesisable, parametrised stimulus source for bench and on-chip self-test. It generates bursts of DATA_W-bit words in one of four patterns: incrementing, 32-bit LFSR pseudo-random, walking-one, or constant. Words are delivered over a valid/ready handshake with back-pressure. The block sits in front of any DUT data input and is the hardware counterpart of bench random-stimulus tasks, adding programmable length, pattern modes and flow control.

---
 rtl/stim_pattern_gen.sv | 134 +++++++++++++
 tb/tb_stim_pattern_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stim_pattern_gen.sv
// Purpose : burst stimulus source with increment, LFSR, walking-one and constant patterns.
// Latency : first word is valid the cycle after start is sampled; one word per cycle thereafter.
// Backpr. : dout and the pattern state hold while dout_vld=1 and dout_rdy=0.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         burst request, honoured only in IDLE
//   mode          0 increment, 1 LFSR, 2 walking-one, 3 constant
//   len           number of words in the burst (0 = empty burst)
//   pat_init      start value (increment) / fixed value (constant)
//   dout/dout_vld/dout_rdy  output word handshake
//   busy          high while words are being issued
//   done          one-cycle pulse after the burst completes
module stim_pattern_gen #(
   parameter int          DATA_W = 8,
   parameter int          CNT_W  = 8,
   parameter logic [31:0] SEED   = 32'h0000_0001
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  len,
   input  logic [DATA_W-1:0] pat_init,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   input  logic              dout_rdy,
   output logic              busy,
   output logic              done
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] dout_q;
   logic [31:0]       lfsr_q;
   logic [31:0]       lfsr_nxt;
   logic [DATA_W-1:0] first_word;
   logic [DATA_W-1:0] next_word;
   logic              xfer;

   assign xfer     = (state_q == RUN) && dout_rdy;
   // The feedback includes bit 31, so the update is invertible and a
   // non-zero state can never step to zero.
   assign lfsr_nxt = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

   // Outputs are decodes of the state flop and the dout register only.
   assign dout     = dout_q;
   assign dout_vld = (state_q == RUN);
   assign busy     = (state_q == RUN);
   assign done     = (state_q == FIN);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? FIN : RUN;
            end
         end
         RUN: begin
            if (xfer && (cnt_q == CNT_W'(1))) begin
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // First word of a burst, taken from the live inputs at start time.
   always_comb begin
      first_word = pat_init;
      case (mode)
         2'd1:    first_word = lfsr_q[DATA_W-1:0];
         2'd2:    first_word = DATA_W'(1);
         default: first_word = pat_init;
      endcase
   end

   // Word following the current one, using the latched mode. The
   // walking-one rotate degenerates to a hold when DATA_W is 1.
   always_comb begin
      next_word = dout_q;
      case (mode_q)
         2'd0:    next_word = dout_q + DATA_W'(1);
         2'd1:    next_word = lfsr_nxt[DATA_W-1:0];
         2'd2:    next_word = (dout_q << 1) | (dout_q >> (DATA_W - 1));
         default: next_word = dout_q;
      endcase
   end

   // Datapath: latch parameters at start, advance the pattern on transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         mode_q <= 2'd0;
         dout_q <= '0;
         lfsr_q <= SEED_EFF;
      end else if ((state_q == IDLE) && start) begin
         cnt_q  <= len;
         mode_q <= mode;
         dout_q <= first_word;
      end else if (xfer) begin
         cnt_q  <= cnt_q - CNT_W'(1);
         dout_q <= next_word;
         // The LFSR only moves when it supplied the word, so successive
         // LFSR bursts continue one sequence.
         if (mode_q == 2'd1) begin
            lfsr_q <= lfsr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Purpose : scoreboard bench for stim_pattern_gen (DATA_W=8, CNT_W=8, SEED=1).
// Latency : expected words are queued before each start and popped per transfer.
// Backpr. : the bench drives dout_rdy directly, including a toggling pattern.
module tb_stim_pattern_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic [7:0] len;
   logic [7:0] pat_init;
   logic [7:0] dout;
   logic       dout_vld;
   logic       dout_rdy;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int  done_cnt   = 0;
   int  xfer_cnt   = 0;
   int  busy_seen  = 0;
   int  vld_seen   = 0;
   bit  toggle_rdy = 0;

   always #10 clk = ~clk;

   stim_pattern_gen #(
      .DATA_W (8),
      .CNT_W  (8),
      .SEED   (32'h0000_0001)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .len      (len),
      .pat_init (pat_init),
      .dout     (dout),
      .dout_vld (dout_vld),
      .dout_rdy (dout_rdy),
      .busy     (busy),
      .done     (done)
   );

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: pops and compares every transfer, checks hold-under-backpressure
   // and the done pulse that must follow the last queued word.
   initial begin : monitor
      logic       prev_vld = 1'b0;
      logic       prev_rdy = 1'b0;
      logic       prev_done = 1'b0;
      logic [7:0] prev_dout = 8'h0;
      bit         pending_done = 0;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_vld = 1'b0;
            prev_done = 1'b0;
            pending_done = 0;
         end else begin
            if (busy) busy_seen++;
            if (dout_vld) vld_seen++;
            if (done && !prev_done) done_cnt++;
            if (pending_done) begin
               check("done_after_last", {31'd0, done}, 1);
               check("vld_low_after_last", {31'd0, dout_vld}, 0);
               pending_done = 0;
            end
            if (prev_vld && !prev_rdy && dout_vld)
               check("hold_under_backpressure", dout, prev_dout);
            if (dout_vld && dout_rdy) begin
               xfer_cnt++;
               if (exp_q.size() == 0) begin
                  check("unexpected_word", dout, 256);
               end else begin
                  e = exp_q.pop_front();
                  check("word", dout, e);
                  if (exp_q.size() == 0) pending_done = 1;
               end
            end
            prev_vld  = dout_vld;
            prev_rdy  = dout_rdy;
            prev_dout = dout;
            prev_done = done;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_rdy) dout_rdy = ~dout_rdy;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_dout", dout, 0);
      check("rst_dout_vld", {31'd0, dout_vld}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
   endtask

   task automatic start_burst(input logic [1:0] m, input logic [7:0] l, input logic [7:0] p);
      mode = m; len = l; pat_init = p; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Waits for done, then steps once more so the FSM is back in IDLE.
   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
      tick();
      toggle_rdy = 0;
   endtask

   task automatic push(input logic [7:0] w);
      exp_q.push_back(w);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 2'd0; len = 8'd0; pat_init = 8'd0; dout_rdy = 1'b0;

      do_reset();
      check_reset_outputs();

      // Reset in the middle of a stalled burst: abandoned, no done.
      start_burst(2'd0, 8'd5, 8'h10);
      tick(); tick();
      do_reset();
      check_reset_outputs();
      tick();
      check("no_done_after_abort", done_cnt, 0);

      // LFSR from seed
      dout_rdy = 1'b1;
      push(8'h01); push(8'h03); push(8'h06); push(8'h0D);
      start_burst(2'd1, 8'd4, 8'h00);
      wait_done(10);
      check("lfsr_done_cnt", done_cnt, 1);
      check("lfsr_q_empty", exp_q.size(), 0);

      // LFSR continuity across bursts
      do_reset();
      push(8'h01); push(8'h03);
      start_burst(2'd1, 8'd2, 8'h00);
      wait_done(10);
      push(8'h06); push(8'h0D);
      start_burst(2'd1, 8'd2, 8'h00);
      wait_done(10);
      check("cont_done_cnt", done_cnt, 3);
      check("cont_q_empty", exp_q.size(), 0);

      // Increment with wrap
      push(8'hFE); push(8'hFF); push(8'h00); push(8'h01);
      start_burst(2'd0, 8'd4, 8'hFE);
      wait_done(10);
      check("inc_done_cnt", done_cnt, 4);
      check("inc_q_empty", exp_q.size(), 0);

      // Walking-one with toggling ready
      xfer_cnt = 0;
      push(8'h01); push(8'h02); push(8'h04); push(8'h08); push(8'h10);
      push(8'h20); push(8'h40); push(8'h80); push(8'h01); push(8'h02);
      dout_rdy = 1'b0;
      toggle_rdy = 1;
      start_burst(2'd2, 8'd10, 8'h00);
      wait_done(40);
      dout_rdy = 1'b1;
      check("walk_xfers", xfer_cnt, 10);
      check("walk_done_cnt", done_cnt, 5);
      check("walk_q_empty", exp_q.size(), 0);

      // Empty burst
      busy_seen = 0; vld_seen = 0;
      start_burst(2'd0, 8'd0, 8'h33);
      wait_done(4);
      tick();
      check("empty_busy_seen", busy_seen, 0);
      check("empty_vld_seen", vld_seen, 0);
      check("empty_done_cnt", done_cnt, 6);

      // Start during RUN is ignored
      xfer_cnt = 0;
      push(8'hA5); push(8'hA5); push(8'hA5);
      start_burst(2'd3, 8'd3, 8'hA5);
      mode = 2'd0; len = 8'd5; pat_init = 8'h00; start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      wait_done(10);
      repeat (4) tick();
      check("const_xfers", xfer_cnt, 3);
      check("const_done_cnt", done_cnt, 7);
      check("const_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
